// File: rtl/systolic_sched_pkg.sv
// Shared definitions for the systolic array scheduler: FSM encoding and default geometry.
// Optional cycle counter is enabled by defining SYSTOLIC_SCHED_PERF_EN.
package systolic_sched_pkg;

  localparam int N_DEFAULT             = 8;
  localparam int BP_WIDTH_DEFAULT      = 3;
  localparam int ADDRESS_WIDTH_DEFAULT = 10;
  localparam int MEM_AMOUNT_DEFAULT    = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_S = 3'd1,
    STREAM = 3'd2,
    WAIT   = 3'd3,
    NEXT   = 3'd4
  } sched_state_e;

endpackage

// File: rtl/systolic_sched_if.sv
// Scheduler-to-array bus: query/reference bases, strobes and the array busy handshake.
interface systolic_sched_if
  import systolic_sched_pkg::*;
#(
  parameter int BP_WIDTH = BP_WIDTH_DEFAULT,
  parameter int LOG_N    = $clog2(N_DEFAULT)
);
  logic [BP_WIDTH-1:0] S;
  logic [BP_WIDTH-1:0] T;
  logic                s_update;
  logic                valid;
  logic                ack;
  logic                new_seq;
  logic                use_s1;
  logic [LOG_N-1:0]    PE_end;
  logic                arr_busy;

  modport master (
    output S, T, s_update, valid, ack, new_seq, use_s1, PE_end,
    input  arr_busy
  );

  modport slave (
    input  S, T, s_update, valid, ack, new_seq, use_s1, PE_end,
    output arr_busy
  );
endinterface

// File: rtl/systolic_sched_addr_gen.sv
// Loadable up-counter that stops at a loaded terminal value; drives buffer read addresses.
module sched_addr_gen #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_i,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] last_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] last_q, last_d;

  // Next count: load wins, otherwise advance until the terminal value is reached.
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (load) begin
      cnt_d  = load_val;
      last_d = last_val;
    end else if (en && !term) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = (cnt_q == last_q);

endmodule

// File: rtl/systolic_sched.sv
// Job scheduler for a systolic alignment array: loads query blocks, streams the reference,
// waits for the array, repeats per block. SYSTOLIC_SCHED_PERF_EN adds a busy-cycle counter.
module systolic_sched
  import systolic_sched_pkg::*;
#(
  parameter int N             = N_DEFAULT,
  parameter int BP_WIDTH      = BP_WIDTH_DEFAULT,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
  parameter int MEM_AMOUNT    = MEM_AMOUNT_DEFAULT,
  parameter int LOG_N         = $clog2(N),
  parameter int BLK_WIDTH     = $clog2(MEM_AMOUNT)
) (
  input  logic                         clk,
  input  logic                         reset_i,
  input  logic                         start,
  input  logic [BLK_WIDTH+LOG_N:0]     qlen,
  input  logic [ADDRESS_WIDTH-1:0]     tlen,
  output logic [BLK_WIDTH+LOG_N-1:0]   q_addr,
  input  logic [BP_WIDTH-1:0]          q_data,
  output logic [ADDRESS_WIDTH-1:0]     r_addr,
  input  logic [BP_WIDTH-1:0]          r_data,
  output logic [BP_WIDTH-1:0]          S,
  output logic [BP_WIDTH-1:0]          T,
  output logic                         s_update,
  output logic                         valid,
  output logic                         ack,
  output logic                         new_seq,
  output logic                         use_s1,
  output logic [LOG_N-1:0]             PE_end,
  input  logic                         arr_busy,
  output logic                         sched_busy,
  output logic                         done,
  output logic                         err
`ifdef SYSTOLIC_SCHED_PERF_EN
  ,
  output logic [31:0]                  cycles
`endif
);

  localparam int QW = BLK_WIDTH + LOG_N + 1;
  localparam int AQ = BLK_WIDTH + LOG_N;
  localparam logic [QW-1:0] QLEN_MAX = QW'(N * MEM_AMOUNT);

  sched_state_e           state_q, state_d;
  logic [BLK_WIDTH-1:0]   blk_q, blk_d;
  logic [QW-1:0]          qlen_q, qlen_d;
  logic [ADDRESS_WIDTH-1:0] tlen_q, tlen_d;
  logic                   load_last_q, load_last_d;
  logic                   str_last_q, str_last_d;
  logic                   seen_busy_q, seen_busy_d;
  logic                   pad_q, pad_d;
  logic                   s_update_q, s_update_d;
  logic                   valid_q, valid_d;
  logic                   ack_q, ack_d;
  logic                   new_seq_q, new_seq_d;
  logic                   use_s1_q, use_s1_d;
  logic [LOG_N-1:0]       pe_end_q, pe_end_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   accept, enter;
  logic [BLK_WIDTH-1:0]   enter_blk;
  logic [QW-1:0]          blk_inc, blk_end, qlen_m1;
  logic                   q_en, r_load, r_en;
  logic [AQ-1:0]          q_cnt;
  logic                   q_term;
  logic [ADDRESS_WIDTH-1:0] r_cnt;
  logic                   r_term;

  sched_addr_gen #(.W(AQ)) u_q_addr (
    .clk      (clk),
    .reset_i  (reset_i),
    .load     (enter),
    .load_val ({enter_blk, {LOG_N{1'b0}}}),
    .last_val ({enter_blk, {LOG_N{1'b1}}}),
    .en       (q_en),
    .cnt      (q_cnt),
    .term     (q_term)
  );

  sched_addr_gen #(.W(ADDRESS_WIDTH)) u_r_addr (
    .clk      (clk),
    .reset_i  (reset_i),
    .load     (r_load),
    .load_val ({ADDRESS_WIDTH{1'b0}}),
    .last_val (tlen_q - ADDRESS_WIDTH'(1)),
    .en       (r_en),
    .cnt      (r_cnt),
    .term     (r_term)
  );

  // FSM next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    qlen_d      = qlen_q;
    tlen_d      = tlen_q;
    load_last_d = 1'b0;
    str_last_d  = 1'b0;
    pad_d       = 1'b0;
    s_update_d  = 1'b0;
    valid_d     = 1'b0;
    new_seq_d   = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    use_s1_d    = use_s1_q;
    pe_end_d    = pe_end_q;
    accept      = 1'b0;
    enter       = 1'b0;
    enter_blk   = '0;
    blk_inc     = QW'(blk_q) + QW'(1);
    q_en        = 1'b0;
    r_load      = 1'b0;
    r_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((qlen == '0) || (tlen == '0) || (qlen > QLEN_MAX)) begin
            err_d = 1'b1;
          end else begin
            accept    = 1'b1;
            enter     = 1'b1;
            qlen_d    = qlen;
            tlen_d    = tlen;
            blk_d     = '0;
            new_seq_d = 1'b1;
            state_d   = LOAD_S;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_S: begin
        // Address issued this cycle returns next cycle; the pad flag travels with it.
        q_en        = ~load_last_q;
        s_update_d  = ~load_last_q;
        pad_d       = ({1'b0, q_cnt} >= qlen_q);
        load_last_d = q_term & ~load_last_q;
        if (load_last_q) begin
          r_load  = 1'b1;
          state_d = STREAM;
        end else begin
          state_d = LOAD_S;
        end
      end
      STREAM: begin
        r_en       = ~str_last_q;
        valid_d    = ~str_last_q;
        str_last_d = r_term & ~str_last_q;
        if (str_last_q) begin
          state_d = WAIT;
        end else begin
          state_d = STREAM;
        end
      end
      WAIT: begin
        if (!arr_busy && seen_busy_q) begin
          state_d = NEXT;
        end else begin
          state_d = WAIT;
        end
      end
      NEXT: begin
        if ((blk_inc << LOG_N) >= qlen_q) begin
          done_d   = 1'b1;
          use_s1_d = ~use_s1_q;
          state_d  = IDLE;
        end else begin
          blk_d     = blk_inc[BLK_WIDTH-1:0];
          enter     = 1'b1;
          enter_blk = blk_inc[BLK_WIDTH-1:0];
          state_d   = LOAD_S;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    blk_end = (QW'(enter_blk) + QW'(1)) << LOG_N;
    qlen_m1 = qlen_d - QW'(1);
    if (enter) begin
      pe_end_d    = (blk_end >= qlen_d) ? qlen_m1[LOG_N-1:0] : LOG_N'(N - 1);
      seen_busy_d = 1'b0;
    end else begin
      seen_busy_d = seen_busy_q | (arr_busy & (state_q != IDLE));
    end
    ack_d  = (state_d == LOAD_S) || (state_d == STREAM) || (state_d == WAIT);
    busy_d = (state_d != IDLE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      qlen_q      <= '0;
      tlen_q      <= '0;
      load_last_q <= 1'b0;
      str_last_q  <= 1'b0;
      seen_busy_q <= 1'b0;
      pad_q       <= 1'b0;
      s_update_q  <= 1'b0;
      valid_q     <= 1'b0;
      ack_q       <= 1'b0;
      new_seq_q   <= 1'b0;
      use_s1_q    <= 1'b0;
      pe_end_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      qlen_q      <= qlen_d;
      tlen_q      <= tlen_d;
      load_last_q <= load_last_d;
      str_last_q  <= str_last_d;
      seen_busy_q <= seen_busy_d;
      pad_q       <= pad_d;
      s_update_q  <= s_update_d;
      valid_q     <= valid_d;
      ack_q       <= ack_d;
      new_seq_q   <= new_seq_d;
      use_s1_q    <= use_s1_d;
      pe_end_q    <= pe_end_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Buffer data passes straight through, gated by registered strobes.
  assign S          = (s_update_q && !pad_q) ? q_data : '0;
  assign T          = valid_q ? r_data : '0;
  assign q_addr     = q_cnt;
  assign r_addr     = r_cnt;
  assign s_update   = s_update_q;
  assign valid      = valid_q;
  assign ack        = ack_q;
  assign new_seq    = new_seq_q;
  assign use_s1     = use_s1_q;
  assign PE_end     = pe_end_q;
  assign sched_busy = busy_q;
  assign done       = done_q;
  assign err        = err_q;

`ifdef SYSTOLIC_SCHED_PERF_EN
  logic [31:0] cycles_q, cycles_d;

  // Busy-cycle count: cleared on accept, saturating.
  always_comb begin
    if (accept) begin
      cycles_d = 32'd0;
    end else if (busy_q && (cycles_q != 32'hFFFF_FFFF)) begin
      cycles_d = cycles_q + 32'd1;
    end else begin
      cycles_d = cycles_q;
    end
  end

  // Busy-cycle counter register.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      cycles_q <= 32'd0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_systolic_sched.sv
// Directed, table-driven bench for systolic_sched with synchronous-read buffer models.
module tb_systolic_sched;
  localparam int N = 8;
  localparam int BPW = 3;
  localparam int AW = 10;
  localparam int MA = 4;
  localparam int LOGN = 3;
  localparam int BLKW = 2;

  logic clk = 1'b0;
  logic reset_i, start;
  logic [BLKW+LOGN:0] qlen;
  logic [AW-1:0] tlen;
  logic [BLKW+LOGN-1:0] q_addr;
  logic [BPW-1:0] q_data, r_data;
  logic [AW-1:0] r_addr;
  logic sched_busy, done, err;
`ifdef SYSTOLIC_SCHED_PERF_EN
  logic [31:0] cycles;
`endif

  logic [BPW-1:0] qmem [0:31];
  logic [BPW-1:0] rmem [0:1023];

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_use = 1'b0;

  typedef struct {
    int ql; int tl; int wlo; bit poke;
    bit exp_err; int exp_blocks; int exp_pe_last;
  } vec_t;
  vec_t vecs [8];

  systolic_sched_if #(.BP_WIDTH(BPW), .LOG_N(LOGN)) arr_if ();

  systolic_sched #(.N(N), .BP_WIDTH(BPW), .ADDRESS_WIDTH(AW), .MEM_AMOUNT(MA),
                   .LOG_N(LOGN), .BLK_WIDTH(BLKW)) dut (
    .clk(clk), .reset_i(reset_i), .start(start), .qlen(qlen), .tlen(tlen),
    .q_addr(q_addr), .q_data(q_data), .r_addr(r_addr), .r_data(r_data),
    .S(arr_if.S), .T(arr_if.T), .s_update(arr_if.s_update), .valid(arr_if.valid),
    .ack(arr_if.ack), .new_seq(arr_if.new_seq), .use_s1(arr_if.use_s1),
    .PE_end(arr_if.PE_end), .arr_busy(arr_if.arr_busy),
    .sched_busy(sched_busy), .done(done), .err(err)
`ifdef SYSTOLIC_SCHED_PERF_EN
    , .cycles(cycles)
`endif
  );

  always #5 clk = ~clk;

  // Buffers with one-cycle synchronous read.
  always @(posedge clk) begin
    q_data <= qmem[q_addr];
    r_data <= rmem[r_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_S"}, 32'(arr_if.S), 32'd0);
    chk({tag, "_T"}, 32'(arr_if.T), 32'd0);
    chk({tag, "_s_update"}, 32'(arr_if.s_update), 32'd0);
    chk({tag, "_valid"}, 32'(arr_if.valid), 32'd0);
    chk({tag, "_ack"}, 32'(arr_if.ack), 32'd0);
    chk({tag, "_new_seq"}, 32'(arr_if.new_seq), 32'd0);
    chk({tag, "_use_s1"}, 32'(arr_if.use_s1), 32'd0);
    chk({tag, "_PE_end"}, 32'(arr_if.PE_end), 32'd0);
    chk({tag, "_busy"}, 32'(sched_busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Runs one job from an IDLE negedge back to IDLE, checking every phase.
  task automatic run_job(input vec_t v);
    int pe, idx;
    start = 1'b1;
    qlen = 6'(v.ql);
    tlen = 10'(v.tl);
    step();
    start = 1'b0;
    if (v.exp_err) begin
      chk("err_pulse", 32'(err), 32'd1);
      chk("err_busy", 32'(sched_busy), 32'd0);
      chk("err_ack", 32'(arr_if.ack), 32'd0);
      step();
      chk("err_clear", 32'(err), 32'd0);
      chk("err_idle", 32'(sched_busy), 32'd0);
      return;
    end
    chk("no_err", 32'(err), 32'd0);
    for (int b = 0; b < v.exp_blocks; b++) begin
      pe = (b == v.exp_blocks - 1) ? v.exp_pe_last : N - 1;
      chk("new_seq", 32'(arr_if.new_seq), (b == 0) ? 32'd1 : 32'd0);
      chk("ack_load", 32'(arr_if.ack), 32'd1);
      chk("busy_load", 32'(sched_busy), 32'd1);
      chk("s_upd_c0", 32'(arr_if.s_update), 32'd0);
      chk("pe_end_load", 32'(arr_if.PE_end), 32'(pe));
      chk("q_addr_c0", 32'(q_addr), 32'(b * N));
      for (int k = 1; k <= N; k++) begin
        step();
        idx = b * N + k - 1;
        chk("s_update", 32'(arr_if.s_update), 32'd1);
        chk("S", 32'(arr_if.S), (idx < v.ql) ? 32'(qmem[idx]) : 32'd0);
        chk("new_seq_low", 32'(arr_if.new_seq), 32'd0);
      end
      step();
      chk("s_upd_off", 32'(arr_if.s_update), 32'd0);
      chk("valid_c0", 32'(arr_if.valid), 32'd0);
      for (int j = 1; j <= v.tl; j++) begin
        if (v.poke && j == 2) begin
          start = 1'b1;
          qlen = 6'd3;
          tlen = 10'd9;
        end
        step();
        start = 1'b0;
        chk("valid", 32'(arr_if.valid), 32'd1);
        chk("T", 32'(arr_if.T), 32'(rmem[j-1]));
        chk("S_off", 32'(arr_if.S), 32'd0);
      end
      step();
      chk("valid_off", 32'(arr_if.valid), 32'd0);
      chk("ack_wait", 32'(arr_if.ack), 32'd1);
      chk("pe_end_wait", 32'(arr_if.PE_end), 32'(pe));
      for (int w = 0; w < v.wlo; w++) begin
        step();
        chk("hold_wait", 32'(arr_if.ack), 32'd1);
      end
      arr_if.arr_busy = 1'b1;
      step();
      chk("busy_hi_wait", 32'(arr_if.ack), 32'd1);
      arr_if.arr_busy = 1'b0;
      step();
      chk("ack_next", 32'(arr_if.ack), 32'd0);
      chk("busy_next", 32'(sched_busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      step();
    end
    exp_use = ~exp_use;
    chk("done", 32'(done), 32'd1);
    chk("idle_after", 32'(sched_busy), 32'd0);
    chk("use_s1", 32'(arr_if.use_s1), 32'(exp_use));
    step();
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    vecs[0] = '{ql: 8,  tl: 5, wlo: 0,  poke: 1'b0, exp_err: 1'b0, exp_blocks: 1, exp_pe_last: 7};
    vecs[1] = '{ql: 11, tl: 4, wlo: 0,  poke: 1'b0, exp_err: 1'b0, exp_blocks: 2, exp_pe_last: 2};
    vecs[2] = '{ql: 0,  tl: 5, wlo: 0,  poke: 1'b0, exp_err: 1'b1, exp_blocks: 0, exp_pe_last: 0};
    vecs[3] = '{ql: 33, tl: 5, wlo: 0,  poke: 1'b0, exp_err: 1'b1, exp_blocks: 0, exp_pe_last: 0};
    vecs[4] = '{ql: 5,  tl: 0, wlo: 0,  poke: 1'b0, exp_err: 1'b1, exp_blocks: 0, exp_pe_last: 0};
    vecs[5] = '{ql: 32, tl: 3, wlo: 0,  poke: 1'b0, exp_err: 1'b0, exp_blocks: 4, exp_pe_last: 7};
    vecs[6] = '{ql: 1,  tl: 1, wlo: 20, poke: 1'b0, exp_err: 1'b0, exp_blocks: 1, exp_pe_last: 0};
    vecs[7] = '{ql: 17, tl: 2, wlo: 0,  poke: 1'b1, exp_err: 1'b0, exp_blocks: 3, exp_pe_last: 0};

    for (int i = 0; i < 32; i++) qmem[i] = 3'((i * 5 + 3) % 8);
    for (int i = 0; i < 1024; i++) rmem[i] = 3'((i * 3 + 1) % 8);

    reset_i = 1'b1;
    start = 1'b0;
    qlen = '0;
    tlen = '0;
    arr_if.arr_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    chk("reset_q_addr", 32'(q_addr), 32'd0);
    chk("reset_r_addr", 32'(r_addr), 32'd0);
    reset_i = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_job(vecs[i]);

    // Reset in STREAM cycle 3 abandons the job; a new start right after release completes.
    start = 1'b1;
    qlen = 6'd8;
    tlen = 10'd6;
    step();
    start = 1'b0;
    repeat (N + 4) step();
    chk("pre_reset_valid", 32'(arr_if.valid), 32'd1);
    chk("pre_reset_T", 32'(arr_if.T), 32'(rmem[2]));
    reset_i = 1'b1;
    step();
    chk_all_zero("midjob_reset");
    reset_i = 1'b0;
    exp_use = 1'b0;
    run_job(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_sched.md
SYSTOLIC_SCHED -- requirements
Module: systolic_sched

Interface
REQ-001 SHALL have parameters: N, default 8, PE count per block; BP_WIDTH, default 3, base width; ADDRESS_WIDTH, default 10, reference address width; MEM_AMOUNT, default 4, maximum query blocks; LOG_N, default 3, equal to clog2(N); BLK_WIDTH, default 2, equal to clog2(MEM_AMOUNT).
REQ-002 SHALL have ports, in order:
- clk  in  1  sole clock.
- reset_i  in  1  synchronous, active-high reset.
- start  in  1  job request.
- qlen  in  BLK_WIDTH+LOG_N+1  query length.
- tlen  in  ADDRESS_WIDTH  reference length.
- q_addr  out  BLK_WIDTH+LOG_N  query buffer read address.
- q_data  in  BP_WIDTH  query base.
- r_addr  out  ADDRESS_WIDTH  reference buffer read address.
- r_data  in  BP_WIDTH  reference base.
- S  out  BP_WIDTH  array S.
- T  out  BP_WIDTH  array T.
- s_update  out  1  array s_update.
- valid  out  1  array valid.
- ack  out  1  array ack.
- new_seq  out  1  array new_seq.
- use_s1  out  1  direction bank select.
- PE_end  out  LOG_N  last active PE.
- arr_busy  in  1  array busy.
- sched_busy  out  1  job in progress.
- done  out  1  job-complete pulse.
- err  out  1  rejected-job pulse.

Function
REQ-003 SHALL implement FSM states IDLE, LOAD_S, STREAM, WAIT, NEXT.
REQ-004 In IDLE, start=1 SHALL latch qlen/tlen, set blk=0, and enter LOAD_S; start in any other state SHALL be ignored.
REQ-005 start in IDLE with qlen=0, tlen=0, or qlen>N*MEM_AMOUNT SHALL pulse err for 1 cycle and remain IDLE.
REQ-006 LOAD_S SHALL last N+1 cycles: q_addr=blk*N+k for k=0..N-1, with synchronous buffer read latency of 1 cycle.
REQ-007 During LOAD_S, S=q_data and s_update=1 SHALL occur in cycles 1..N; S SHALL be 0 when blk*N+k>=qlen.
REQ-008 new_seq SHALL pulse for 1 cycle in the first LOAD_S cycle of blk 0 only.
REQ-009 ack SHALL be 1 from LOAD_S entry until WAIT exit, and 0 otherwise.
REQ-010 STREAM SHALL issue r_addr=0..tlen-1 over tlen cycles; T=r_data and valid=1 SHALL follow each address by 1 cycle, giving tlen consecutive valid cycles.
REQ-011 STREAM SHALL take tlen+1 cycles, then enter WAIT.
REQ-012 WAIT SHALL exit to NEXT on the first cycle where arr_busy=0 after at least one arr_busy=1 cycle seen since LOAD_S entry.
REQ-013 NEXT SHALL be 1 cycle: blk+1; if blk*N>=qlen after increment, SHALL pulse done, toggle use_s1, and go IDLE; otherwise SHALL go LOAD_S.
REQ-014 PE_end SHALL be (qlen-1) mod N for the last block, and N-1 otherwise; it SHALL be stable from LOAD_S through WAIT.
REQ-015 sched_busy SHALL equal (state != IDLE).
REQ-016 S, T, s_update, and valid SHALL be 0 outside the cycles stated above.

Reset
REQ-017 While reset_i=1 at a clk edge, the block SHALL enter IDLE, clear blk/counters, and drive all outputs to 0, including use_s1=0.
REQ-018 Reset asserted mid-job SHALL abandon the job with no done pulse; after release, the block SHALL accept start next cycle.

Configuration
REQ-019 With SYSTOLIC_SCHED_PERF_EN defined, output cycles (32 bits) SHALL count clk cycles with sched_busy=1. It SHALL clear on job accept, hold after done, and saturate at all-ones.
REQ-020 Without SYSTOLIC_SCHED_PERF_EN, the cycles port and counter SHALL not exist.

Structure
REQ-021 FSM state encoding and defaults for N/BP_WIDTH/ADDRESS_WIDTH/MEM_AMOUNT SHALL live in the shared define package.
REQ-022 The address/stream counter SHALL be one sub-module, sched_addr_gen (load, count enable, terminal flag), instantiated twice: query and reference.

Verification
REQ-023 N=8, qlen=8, tlen=5 -> 9-cycle LOAD_S with s_update on cycles 1..8; 5 valid cycles, T matching r_data[0..4]; PE_end=7; done once; use_s1 0->1.
REQ-024 qlen=11, tlen=4 -> two blocks; block 1 S values at indices 11..15 are 0; PE_end=7 then 2; new_seq pulses exactly once.
REQ-025 qlen=0, or qlen=33 with MEM_AMOUNT=4 -> err pulse, no state change, sched_busy=0.
REQ-026 start during STREAM -> ignored, and the job completes unchanged.
REQ-027 Reset in cycle 3 of STREAM -> outputs 0 next cycle, no done; a new start then completes normally.
REQ-028 Hold arr_busy low for 20 cycles after STREAM -> scheduler stays in WAIT; arr_busy 1 then 0 -> NEXT.
